// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding,
// data/address widths and the prefetch queue entry layout.
package fetch_pkg;

    localparam int INS_W  = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with simultaneous push/pop, flush and a
// registered head entry so the consumer never sees the write data combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_din,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    fetch_entry_t       r_head;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_pop;
    logic [PTR_W-1:0]   w_rd_next;
    logic [CNT_W-1:0]   w_count_next;
    fetch_entry_t       w_head_next;

    assign w_pop        = i_pop && (r_count != '0);
    assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_next = r_count + CNT_W'(i_push) - CNT_W'(w_pop);

    // The entry that becomes head may be the one being written this cycle.
    assign w_head_next  = (i_push && (w_rd_next == r_wr_ptr)) ? i_din : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_count_next != '0) begin
                r_head <= w_head_next;
            end
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, single-outstanding ROM read handshake and prefetch
// queue with branch flush. Optional FETCH_PERF_EN adds stall/flush counters.
module ins_fetch
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    output logic              en_ram_in,
    input  logic              en_ram_out,
    input  logic [INS_W-1:0]  ins,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_en;

    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_level;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;

    assign ins_valid    = (w_count != '0);
    assign w_pop        = ins_valid && ins_ready;
    assign w_level      = w_count - CNT_W'(w_pop);
    assign w_push       = (r_state == ST_WAIT) && en_ram_out && !br_valid;
    assign w_push_entry = '{ins: ins, pc: r_addr};

    // Issuing only from IDLE means the read's slot is reserved before it returns.
    assign w_issue = (r_state == ST_IDLE) && !br_valid && (w_level < DEPTH_C);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue)    w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (en_ram_out)      w_state_next = ST_IDLE;
                else if (br_valid)   w_state_next = ST_DROP;
            end
            ST_DROP: if (en_ram_out) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en    <= w_issue;
            if (br_valid) begin
                r_pc <= br_target;
            end else if (w_issue) begin
                r_addr <= r_pc;
                r_pc   <= r_pc + 16'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (br_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign addr      = r_addr;
    assign en_ram_in = r_en;
    assign ins_out   = w_head.ins;
    assign ins_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ins_ready && !ins_valid && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (br_valid && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: ROM model with configurable latency, sequential-PC
// scoreboard for requests and deliveries, directed branch/reset/full cases, random phase.
module tb_ins_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        en_ram_in;
    logic        en_ram_out;
    logic [15:0] ins;
    logic [15:0] ins_out;
    logic [15:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        br_valid;
    logic [15:0] br_target;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    ins_fetch #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .en_ram_in  (en_ram_in),
        .en_ram_out (en_ram_out),
        .ins        (ins),
        .ins_out    (ins_out),
        .ins_pc     (ins_pc),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .br_valid   (br_valid),
        .br_target  (br_target)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Program ROM contents: a fixed scramble of the address.
    function automatic logic [15:0] rom_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    logic [15:0] exp_req, exp_del, last_addr, rom_addr;
    bit          rom_busy, en_seen, resp_now, after_br;
    int          rom_wait, lat_min, lat_max;
    int          n_req, n_del, n_br, n_stall;

    // First half of a cycle: observe outputs after the edge, then drive the ROM.
    task automatic cyc_begin();
        @(negedge clk);
        en_seen  = en_ram_in;
        resp_now = 1'b0;
        if (after_br) begin
            chk("flush_empty", ins_valid, 0);
            after_br = 1'b0;
        end
        if (en_ram_in) begin
            chk("one_outstanding", rom_busy, 0);
            chk("req_addr", addr, exp_req);
            exp_req   = exp_req + 16'd1;
            last_addr = addr;
            rom_addr  = addr;
            rom_busy  = 1'b1;
            rom_wait  = $urandom_range(lat_max, lat_min);
            n_req++;
        end else begin
            chk("addr_stable", addr, last_addr);
        end
        en_ram_out = 1'b0;
        ins        = 16'($urandom);
        if (rom_busy && !en_ram_in) begin
            rom_wait--;
            if (rom_wait == 0) begin
                en_ram_out = 1'b1;
                ins        = rom_f(rom_addr);
                rom_busy   = 1'b0;
                resp_now   = 1'b1;
            end
        end
    endtask

    // Second half: decoder and branch inputs; score any delivery this cycle.
    task automatic cyc_end(input bit rdy, input bit br, input logic [15:0] tgt);
        ins_ready = rdy;
        br_valid  = br;
        br_target = tgt;
        if (rdy && !ins_valid) n_stall++;
        if (ins_valid && rdy) begin
            chk("del_pc", ins_pc, exp_del);
            chk("del_ins", ins_out, rom_f(exp_del));
            exp_del = exp_del + 16'd1;
            n_del++;
        end
        if (br) begin
            exp_req  = tgt;
            exp_del  = tgt;
            after_br = 1'b1;
            n_br++;
        end
    endtask

    task automatic do_reset(input int ncyc, input bit stale, input bit rdy_after);
        rst        = 1'b1;
        ins_ready  = 1'b0;
        br_valid   = 1'b0;
        en_ram_out = 1'b0;
        repeat (ncyc) @(negedge clk);
        chk("rst_en", en_ram_in, 0);
        chk("rst_addr", addr, RESET_PC);
        chk("rst_valid", ins_valid, 0);
        chk("rst_ins", ins_out, 0);
        chk("rst_pc", ins_pc, 0);
`ifdef FETCH_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
`endif
        rst       = 1'b0;
        exp_req   = RESET_PC;
        exp_del   = RESET_PC;
        last_addr = RESET_PC;
        after_br  = 1'b0;
        n_br      = 0;
        // A response still owed from before reset lands while the DUT is idle.
        if (stale && rom_busy) begin
            en_ram_out = 1'b1;
            ins        = 16'hBEEF;
        end
        rom_busy  = 1'b0;
        ins_ready = rdy_after;
        n_stall   = rdy_after ? 1 : 0;
    endtask

    task automatic run(input int n, input int rdy_pct, input int br_pct);
        bit          rdy, br;
        logic [15:0] tgt;
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            rdy = ($urandom_range(99, 0) < rdy_pct);
            br  = ($urandom_range(99, 0) < br_pct) ||
                  (resp_now && (br_pct > 0) && ($urandom_range(3, 0) == 0));
            tgt = ($urandom_range(3, 0) == 0) ? (16'hFFFC + 16'($urandom_range(3, 0)))
                                              : 16'($urandom);
            cyc_end(rdy, br, tgt);
        end
    endtask

    // Both leave the bench in the first half of the cycle where the event was seen.
    task automatic wait_en();
        cyc_begin();
        for (int i = 0; i < 20 && !en_seen; i++) begin
            cyc_end(1'b1, 1'b0, 16'h0);
            cyc_begin();
        end
        if (!en_seen) chk("timeout_en", en_seen, 1);
    endtask

    task automatic wait_resp();
        cyc_begin();
        for (int i = 0; i < 20 && !resp_now; i++) begin
            cyc_end(1'b1, 1'b0, 16'h0);
            cyc_begin();
        end
        if (!resp_now) chk("timeout_resp", resp_now, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; en_ram_out = 1'b0; ins = '0; ins_ready = 1'b0;
        br_valid = 1'b0; br_target = '0;
        rom_busy = 1'b0; rom_wait = 0; after_br = 1'b0;
        lat_min = 2; lat_max = 2;
        n_req = 0; n_del = 0; n_br = 0; n_stall = 0;

        // Sequential fetch with fixed 2-cycle ROM latency.
        do_reset(2, 1'b0, 1'b1);
        cyc_begin();
        chk("first_req", en_seen, 1);
        cyc_end(1'b1, 1'b0, 16'h0);
        wait_resp();
        cyc_end(1'b1, 1'b0, 16'h0);
        cyc_begin();
        chk("valid_latency", ins_valid, 1);
        cyc_end(1'b1, 1'b0, 16'h0);
        run(30, 100, 0);

        // Decoder stalled: exactly DEPTH requests, then resume immediately.
        do_reset(1, 1'b0, 1'b0);
        base = n_req;
        run(40, 0, 0);
        cyc_begin();
        chk("full_reqs", n_req - base, DEPTH);
        chk("full_valid", ins_valid, 1);
        chk("full_no_req", en_seen, 0);
        cyc_end(1'b1, 1'b0, 16'h0);
        cyc_begin();
        chk("resume_req", en_seen, 1);
        cyc_end(1'b1, 1'b0, 16'h0);
        run(20, 100, 0);

        // Branch while a read is outstanding.
        wait_en();
        cyc_end(1'b1, 1'b1, 16'h0040);
        run(20, 100, 0);

        // Branch in the same cycle as a response.
        wait_resp();
        cyc_end(1'b1, 1'b1, 16'h0100);
        run(20, 100, 0);

        // PC wrap.
        cyc_begin();
        cyc_end(1'b1, 1'b1, 16'hFFFE);
        run(20, 100, 0);

        // Reset while a read is outstanding, stale response afterwards.
        wait_en();
        cyc_end(1'b1, 1'b0, 16'h0);
        do_reset(1, 1'b1, 1'b1);
        cyc_begin();
        chk("restart_req", en_seen, 1);
        cyc_end(1'b1, 1'b0, 16'h0);
        run(20, 100, 0);

        // Random traffic.
        lat_min = 1; lat_max = 3;
        run(1500, 75, 4);

        cyc_begin();
        chk("deliveries_seen", (n_del > 100), 1);
`ifdef FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, n_stall);
        chk("flush_cnt", flush_cnt, n_br);
`endif
        cyc_end(1'b0, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
